// File: rtl/alu_rr_issue_if.sv
// alu_rr_issue_if: requester-side request/grant/result bundle for the shared ALU issue controller
interface alu_rr_issue_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 3
);
  logic                 en;
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     lock;
  logic [3*N_REQ-1:0]   sel;
  logic [4*N_REQ-1:0]   rs;
  logic [4*N_REQ-1:0]   rt;
  logic [N_REQ-1:0]     gnt;
  logic                 res_valid;
  logic [3:0]           res;
  logic [ID_W-1:0]      res_id;
  logic [7:0]           issue_cnt;
  modport master (output en, req, lock, sel, rs, rt, input gnt, res_valid, res, res_id, issue_cnt);
  modport slave  (input en, req, lock, sel, rs, rt, output gnt, res_valid, res, res_id, issue_cnt);
endinterface

// File: rtl/alu_rr_issue.sv
// alu_rr_issue: round-robin issue controller sharing one 4-bit ALU among N_REQ requesters
module alu_rr_issue #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 3
) (
  input logic           clk,
  input logic           rst_n,
  alu_rr_issue_if.slave bus
);
  localparam int NP = 2 ** ID_W;
  logic [ID_W-1:0] r_ptr, r_iid, r_res_id, w_win;
  logic [2:0]      r_isel;
  logic [3:0]      r_irs, r_irt, r_res, w_alu;
  logic            r_iv, r_res_valid, w_any, w_grant;
  logic [7:0]      r_cnt;
  logic [NP-1:0]   w_req, w_lock;
  logic [2:0]      w_sel [NP];
  logic [3:0]      w_rs [NP];
  logic [3:0]      w_rt [NP];
  logic [ID_W:0]   w_idx;

  // pad requester slices out to 2^ID_W entries so any tag value indexes safely
  always_comb begin
    w_req  = '0;
    w_lock = '0;
    for (int i = 0; i < NP; i++) begin
      w_sel[i] = '0;
      w_rs[i]  = '0;
      w_rt[i]  = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i]  = bus.req[i];
      w_lock[i] = bus.lock[i];
      w_sel[i]  = bus.sel[3*i +: 3];
      w_rs[i]   = bus.rs[4*i +: 4];
      w_rt[i]   = bus.rt[4*i +: 4];
    end
  end

  // first pending requester scanning upward from the priority pointer wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      w_idx = (w_idx >= (ID_W+1)'(N_REQ)) ? w_idx - (ID_W+1)'(N_REQ) : w_idx;
      if (!w_any && w_req[w_idx[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_grant = w_any && bus.en && rst_n;
  assign bus.gnt = w_grant ? (N_REQ)'(1) << w_win : '0;

  // shared ALU evaluated on the issue-stage registers
  always_comb begin
    case (r_isel)
      3'd0:    w_alu = r_irs - r_irt;
      3'd1:    w_alu = r_irs + r_irt;
      3'd2:    w_alu = r_irs | r_irt;
      3'd3:    w_alu = r_irs & r_irt;
      3'd4:    w_alu = {r_irt[0], r_irt[3:1]};
      3'd5:    w_alu = {r_irs[2:0], r_irs[3]};
      3'd6:    w_alu = {3'b101, r_irs < r_irt};
      default: w_alu = {3'b111, r_irs == r_irt};
    endcase
  end

  // locked winner keeps priority, otherwise priority moves just past the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (w_grant) r_ptr <= w_lock[w_win] ? w_win : (w_win == (ID_W)'(N_REQ-1) ? '0 : w_win + 1'b1);
  end

  // issue stage captures the winner's operation; valid drops on any edge without a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iv   <= 1'b0;
      r_isel <= '0;
      r_irs  <= '0;
      r_irt  <= '0;
      r_iid  <= '0;
    end else begin
      r_iv <= w_grant;
      if (w_grant) begin
        r_isel <= w_sel[w_win];
        r_irs  <= w_rs[w_win];
        r_irt  <= w_rt[w_win];
        r_iid  <= w_win;
      end
    end
  end

  // result stage; data and tag hold their last values between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_res_id    <= '0;
    end else begin
      r_res_valid <= r_iv;
      if (r_iv) begin
        r_res    <= w_alu;
        r_res_id <= r_iid;
      end
    end
  end

  // saturating grant counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_grant && r_cnt != 8'hFF) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res       = r_res;
  assign bus.res_id    = r_res_id;
  assign bus.issue_cnt = r_cnt;
endmodule

// File: tb/tb_alu_rr_issue.sv
// tb_alu_rr_issue: directed stimulus with a queue-based reference model and literal spot checks
module tb_alu_rr_issue;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n;
  alu_rr_issue_if #(.N_REQ(N), .ID_W(3)) bus();
  alu_rr_issue #(.N_REQ(N), .ID_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  typedef struct {int due; int val; int id;} res_t;
  res_t q[$];
  int cyc = 0, m_ptr = 0, m_cnt = 0, m_last_res = 0, m_last_id = 0, m_win = -1, m_val = 0;
  bit m_vld = 1'b0, m_lk = 1'b0;
  int g[7], ids[7], rv[7], rr[7];

  function automatic int alu(input int op, input int a, input int b);
    case (op)
      0: return (a - b) & 15;
      1: return (a + b) & 15;
      2: return a | b;
      3: return a & b;
      4: return ((b >> 1) | (b << 3)) & 15;
      5: return ((a << 1) | (a >> 3)) & 15;
      6: return 10 + ((a < b) ? 1 : 0);
      default: return 14 + ((a == b) ? 1 : 0);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // compare every cycle against the model; also decide this cycle's expected winner
  always @(negedge clk) begin
    int w;
    w = -1;
    if (rst_n === 1'b1 && bus.en === 1'b1)
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req[(m_ptr + k) % N] === 1'b1) w = (m_ptr + k) % N;
    m_win = w;
    if (w >= 0) begin
      m_lk  = bus.lock[w];
      m_val = alu(int'((bus.sel >> (3*w)) & 12'h7), int'((bus.rs >> (4*w)) & 16'hF), int'((bus.rt >> (4*w)) & 16'hF));
    end
    chk("gnt", 32'(bus.gnt), (w < 0) ? 0 : (1 << w));
    chk("res_valid", 32'(bus.res_valid), 32'(m_vld));
    chk("res", 32'(bus.res), m_last_res);
    chk("res_id", 32'(bus.res_id), m_last_id);
    chk("issue_cnt", 32'(bus.issue_cnt), m_cnt);
  end

  // reference model: grants queue a result due two edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0; m_ptr = 0; m_cnt = 0; m_last_res = 0; m_last_id = 0; m_vld = 1'b0;
    end else begin
      cyc++;
      m_vld = q.size() > 0 && q[0].due == cyc;
      if (m_vld) begin
        m_last_res = q[0].val;
        m_last_id  = q[0].id;
        void'(q.pop_front());
      end
      if (m_win >= 0) begin
        q.push_back('{cyc + 1, m_val, m_win});
        m_ptr = m_lk ? m_win : (m_win + 1) % N;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ops[4] = '{0, 6, 4, 5};
    int av[4]  = '{2, 3, 0, 8};
    int bv[4]  = '{5, 5, 1, 0};
    int ev[4]  = '{13, 11, 8, 1};
    int eg[5]  = '{1, 2, 4, 8, 1};
    int ei[5]  = '{0, 1, 2, 3, 0};
    int el[5]  = '{1, 1, 1, 1, 4};
    rst_n = 1'b0; bus.en = 1'b0; bus.req = '0; bus.lock = '0; bus.sel = '0; bus.rs = '0; bus.rt = '0;
    repeat (2) step();
    rst_n = 1'b1;
    mid();
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res", 32'(bus.res), 0);
    chk("rst_cnt", 32'(bus.issue_cnt), 0);
    // single ADD on requester 0
    step();
    bus.en = 1'b1; bus.req = 4'b0001; bus.sel[2:0] = 3'd1; bus.rs[3:0] = 4'd3; bus.rt[3:0] = 4'd4;
    mid();
    chk("add_gnt", 32'(bus.gnt), 1);
    step();
    bus.req = '0;
    step();
    mid();
    chk("add_valid", 32'(bus.res_valid), 1);
    chk("add_res", 32'(bus.res), 7);
    chk("add_id", 32'(bus.res_id), 0);
    // reset with the pipeline full
    step();
    bus.req = 4'b1111; bus.sel = 12'h249; bus.rs = 16'hFFFF; bus.rt = 16'h0000;
    step();
    step();
    mid();
    chk("pre_rst_valid", 32'(bus.res_valid), 1);
    chk("pre_rst_res", 32'(bus.res), 15);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.res_valid), 0);
    chk("mrst_res", 32'(bus.res), 0);
    chk("mrst_cnt", 32'(bus.issue_cnt), 0);
    chk("mrst_gnt", 32'(bus.gnt), 0);
    bus.req = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) begin
      mid();
      chk("post_rst_no_res", 32'(bus.res_valid), 0);
      step();
    end
    // round robin, pointer at 0
    bus.sel = 12'h249; bus.rs = 16'h3210; bus.rt = 16'h1111; bus.req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      mid();
      g[k] = int'(bus.gnt); ids[k] = int'(bus.res_id); rv[k] = int'(bus.res_valid);
      step();
      if (k == 4) bus.req = '0;
    end
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(g[k]), 32'(eg[k]));
      chk("rr_id", 32'(ids[k+2]), 32'(ei[k]));
      chk("rr_valid", 32'(rv[k+2]), 1);
    end
    // move pointer from 1 to 0 via a lone grant to requester 3
    bus.req = 4'b1000;
    mid();
    chk("r3_gnt", 32'(bus.gnt), 8);
    step();
    // lock on requester 0 for three grants
    bus.req = 4'b0101; bus.lock = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      mid();
      g[k] = int'(bus.gnt);
      step();
      if (k == 2) bus.lock = '0;
      if (k == 4) bus.req = '0;
    end
    for (int k = 0; k < 5; k++) chk("lock_gnt", 32'(g[k]), 32'(el[k]));
    bus.req = 4'b1111;
    mid();
    chk("lock_ptr3", 32'(bus.gnt), 8);
    step();
    bus.req = '0;
    // opcode spot checks via requester 1
    step();
    bus.req = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        bus.sel[5:3] = 3'(ops[k]); bus.rs[7:4] = 4'(av[k]); bus.rt[7:4] = 4'(bv[k]);
      end
      mid();
      rr[k] = int'(bus.res); ids[k] = int'(bus.res_id); rv[k] = int'(bus.res_valid);
      step();
      if (k == 3) bus.req = '0;
    end
    for (int k = 0; k < 4; k++) begin
      chk("op_res", 32'(rr[k+2]), 32'(ev[k]));
      chk("op_id", 32'(ids[k+2]), 1);
      chk("op_valid", 32'(rv[k+2]), 1);
    end
    // enable low with one op in flight and requester 3 waiting
    bus.req = 4'b0001; bus.sel[2:0] = 3'd1; bus.rs[3:0] = 4'd5; bus.rt[3:0] = 4'd6;
    mid();
    chk("en_gnt0", 32'(bus.gnt), 1);
    step();
    bus.en = 1'b0; bus.req = 4'b1000;
    mid();
    chk("en_low_gnt_a", 32'(bus.gnt), 0);
    step();
    mid();
    chk("en_low_gnt_b", 32'(bus.gnt), 0);
    chk("en_inflight_valid", 32'(bus.res_valid), 1);
    chk("en_inflight_res", 32'(bus.res), 11);
    chk("en_inflight_id", 32'(bus.res_id), 0);
    step();
    bus.en = 1'b1;
    mid();
    chk("en_resume_gnt", 32'(bus.gnt), 8);
    step();
    // counter saturation
    bus.req = 4'b1111;
    repeat (300) step();
    bus.req = '0;
    mid();
    chk("cnt_sat", 32'(bus.issue_cnt), 255);
    step();
    mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_rr_issue.md
# alu_rr_issue

Round-robin issue controller sharing one `Decode_And_Execute` 4-bit ALU among `N_REQ` requesters. Each cycle it selects at most one pending request, registers its opcode and operands into an issue stage, and returns a registered, requester-tagged result two cycles after grant. It sits between the lab's requester blocks (sequencers, test drivers) and the single ALU instance. It owns arbitration, optional grant locking, drain/enable control and an issue counter.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 3: requester-tag width; must satisfy 2^ID_W >= N_REQ.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  issue enable. When low, no new grants; in-flight operations complete.
- `req`  in  N_REQ  request valid per requester; `sel`/`rs`/`rt` slice held stable while high.
- `lock`  in  N_REQ  requester keeps priority after its grant.
- `sel`  in  3*N_REQ  opcode for requester i at [3i+2:3i].
- `rs`  in  4*N_REQ  rs operand for requester i at [4i+3:4i].
- `rt`  in  4*N_REQ  rt operand for requester i at [4i+3:4i].
- `gnt`  out  N_REQ  one-hot grant, combinational; request accepted at the clock edge ending the cycle.
- `res_valid`  out  1  result valid, one-cycle pulse per issued operation.
- `res`  out  4  ALU result.
- `res_id`  out  ID_W  index of the requester that owns `res`.
- `issue_cnt`  out  8  saturating count of grants since reset.

## Operation
- **ALU opcode semantics** (fixed by the shared ALU):
  - 0: rs-rt mod 16.
  - 1: rs+rt mod 16.
  - 2: rs|rt.
  - 3: rs&rt.
  - 4: rt rotated right by 1.
  - 5: rs rotated left by 1.
  - 6: {3'b101, rs<rt unsigned}.
  - 7: {3'b111, eq flag}.
- **Arbitration.** Priority pointer `ptr` (0..N_REQ-1).
  - Winner is the first i with `req[i]` high, scanning `ptr`, `ptr+1`, … mod N_REQ.
  - `gnt[i]` is high only if `en`=1 and `rst_n`=1.
- **Pointer update on a grant to i.**
  - If `lock[i]`=1: `ptr` stays at i.
  - Otherwise: `ptr` ← (i+1) mod N_REQ.
  - No grant: `ptr` holds.
- **Issue stage.** On a grant edge, register `sel`/`rs`/`rt` of the winner, its index, and stage-valid. Stage-valid clears on any edge with no grant.
- **Result stage.** ALU output is computed from the issue-stage registers. On each edge, `res`, `res_id` and `res_valid` take the ALU result, stage index and stage-valid.
- **Outputs with no valid result.** When `res_valid`=0, `res` and `res_id` hold their last values.
- **Issue counter.** `issue_cnt` increments on every grant and saturates at 255.
- **Request lifetime.** A requester deasserts `req[i]` (or presents a new operation) in the cycle after seeing `gnt[i]`. A `req[i]` still high is treated as a new request.

## Timing
- **Reset values:**
  - `res_valid`=0, `res`=0, `res_id`=0, `issue_cnt`=0.
  - `ptr`=0, stage-valid=0.
  - `gnt`=0 while `rst_n`=0.
- **Latency and throughput.**
  - A grant in cycle t gives `res_valid`=1 in cycle t+2.
  - Throughput is one operation per cycle, with back-to-back grants to any mix of requesters.
- **Lock.** A requester holding `lock` with `req` continuously high is granted every cycle. Others starve until its `lock` or `req` drops.
- **`en` falling.** Grants stop in that same cycle. Operations granted in t-1 and t-2 still produce results in t and t+1.
- **`en` rising.** The pointer is unchanged and arbitration resumes from it.
- **Reset mid-operation.** `res_valid` clears asynchronously and in-flight operations are discarded, with no later result. After release, the first grant takes the normal 2 cycles.
- **Requests with no response.** `req` deasserted before a grant is dropped silently. Any `req` bits above N_REQ-1 do not exist.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic with stage full -> `res_valid`=0, `res`=0, `issue_cnt`=0, `gnt`=0 immediately. No result after release.
- **Single ADD:** req0 only, `sel`=1, rs=3, rt=4, granted at t -> `gnt`=0001 at t; `res_valid`=1, `res`=7, `res_id`=0 at t+2.
- **Round-robin:** all four `req` held high, no lock, ptr=0 -> `gnt` sequence 0001,0010,0100,1000,0001. `res_id` sequence 0,1,2,3,0 starting two cycles later.
- **Lock:** req0 and req2 high, `lock[0]` high for 3 grants then low -> grants 0,0,0,0,2. `ptr` ends at 3.
- **Opcode spot checks** via requester 1:
  - `sel`=0, rs=2, rt=5 -> 4'b1101.
  - `sel`=6, rs=3, rt=5 -> 4'b1011.
  - `sel`=4, rt=4'b0001 -> 4'b1000.
  - `sel`=5, rs=4'b1000 -> 4'b0001.
  - Each result has `res_id`=1.
- **Enable and saturation:**
  - `en` low 2 cycles with req3 pending, one op in flight -> no `gnt`; in-flight result still appears; req3 granted the first cycle `en`=1.
  - 300 grants -> `issue_cnt`=255.
